// File: rtl/mem_port_arbiter.sv
// Byte-wide memory port arbiter: the instruction fetcher owns the port by default,
// and data transactions of 1/2/4/8 bytes borrow it one byte per cycle, little-endian.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 64,
  parameter int          FETCH_MIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [7:0]        f_data,
  output logic              f_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_busy,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [7:0]        m_rdata,
  output logic [7:0]        m_wdata,
  output logic              m_we
);

  localparam int unsigned GAP_MIN = (FETCH_MIN < 1) ? 1 : FETCH_MIN;
  localparam int unsigned GAP_W   = $clog2(GAP_MIN + 1);
  // The last fetcher-owned cycle before the next latch is spent in IDLE, so GAP
  // itself lasts GAP_MIN-1 cycles (never fewer than the single ack cycle).
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'((GAP_MIN >= 2) ? GAP_MIN - 2 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [2:0]        last_q;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base_q;
  logic [63:0]       wdata_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              ack_q;
  logic [63:0]       rdata_q;
  logic              latch;
  logic              done;
  logic              in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req) begin
          latch    = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (cnt == last_q) begin
          done     = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_data = (state == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      last_q  <= '0;
      cnt     <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      gap_cnt <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= done;

      if (latch) begin
        we_q    <= d_we;
        last_q  <= {d_size == 2'd3, d_size[1], d_size != 2'd0};
        base_q  <= d_addr;
        wdata_q <= d_wdata;
        cnt     <= '0;
        if (!d_we) begin
          rdata_q <= '0;
        end
      end

      if (in_data) begin
        cnt <= cnt + 3'd1;
        if (!we_q) begin
          rdata_q[{cnt, 3'b000} +: 8] <= m_rdata;
        end
      end

      if (done) begin
        gap_cnt <= GAP_LD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign f_stall = in_data;
  assign d_busy  = in_data;
  assign m_addr  = in_data ? base_q + ADDR_W'(cnt) : f_addr;
  assign m_we    = in_data & we_q;
  assign m_wdata = wdata_q[{cnt, 3'b000} +: 8];
  assign f_data  = m_rdata;
  assign d_ack   = ack_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte memory model, per-cycle port checks,
// and a queue of expected load results compared at each d_ack.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] f_addr;
  logic [7:0]    f_data;
  logic          f_stall;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          d_busy;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_rdata;
  logic [7:0]    m_wdata;
  logic          m_we;

  logic [7:0]  mem [256];
  logic        mem_init;
  logic [63:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_port_arbiter #(.ADDR_W(AW), .FETCH_MIN(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_addr  (f_addr),
    .f_data  (f_data),
    .f_stall (f_stall),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_busy  (d_busy),
    .m_addr  (m_addr),
    .m_rdata (m_rdata),
    .m_wdata (m_wdata),
    .m_we    (m_we)
  );

  always #5 clk = ~clk;

  // Memory indexed by the low address byte; preload 0x10..0x17 with 01..08.
  assign m_rdata = mem[m_addr[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        if (i >= 16'h10 && i <= 16'h17) mem[i] = 8'(i - 16'h0F);
        else                            mem[i] = 8'(i) ^ 8'hA5;
      end
    end else if (m_we) begin
      mem[m_addr[7:0]] = m_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns in the ack cycle.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic [63:0] a,
                      input logic [63:0] wd, input logic [63:0] exp, input logic keep);
    int unsigned n;
    logic [63:0] got;
    n = 1 << sz;
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    exp_q.push_back(exp);
    #1;
    chk("pre_stall", f_stall, 0);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      d_addr = ~a; d_wdata = ~wd; d_size = ~sz; d_we = ~we;
      #1;
      chk("dat_stall", f_stall, 1);
      chk("dat_busy", d_busy, 1);
      chk("dat_ack", d_ack, 0);
      chk("dat_addr", m_addr, a + 64'(i));
      chk("dat_we", m_we, we);
      if (we) chk("dat_wdata", m_wdata, wd[8*i +: 8]);
    end
    tick();
    #1;
    chk("ack", d_ack, 1);
    chk("ack_stall", f_stall, 0);
    chk("ack_busy", d_busy, 0);
    chk("sb_depth", exp_q.size(), 1);
    got = exp_q.pop_front();
    chk("rdata", d_rdata, got);
    if (!keep) d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; d_req = 1'b0; d_we = 1'b0; d_size = 2'd0;
    d_addr = '0; d_wdata = '0; f_addr = 64'h100;
    tick();
    tick();
    chk("rst_stall", f_stall, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_ack", d_ack, 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_we", m_we, 0);
    rst = 1'b0; mem_init = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      f_addr = 64'h100 + 64'(k);
      #1;
      chk("fetch_addr", m_addr, 64'h100 + 64'(k));
      chk("fetch_data", f_data, 8'(k) ^ 8'hA5);
      chk("fetch_stall", f_stall, 0);
      chk("fetch_we", m_we, 0);
      tick();
    end

    xfer(1'b0, 2'd3, 64'h10, 64'h0, 64'h0807060504030201, 1'b0);
    tick(); chk("ack_pulse", d_ack, 0);

    xfer(1'b1, 2'd1, 64'h20, 64'hBEEF, 64'h0807060504030201, 1'b0);
    tick(); chk("ack_pulse", d_ack, 0);
    chk("mem_20", mem[8'h20], 8'hEF);
    chk("mem_21", mem[8'h21], 8'hBE);

    xfer(1'b0, 2'd1, 64'h20, 64'h0, 64'h000000000000BEEF, 1'b0);
    tick(); chk("ack_pulse", d_ack, 0);

    // d_req held through the ack cycle: second latch only at the end of the next cycle.
    xfer(1'b0, 2'd1, 64'h10, 64'h0, 64'h0000000000000201, 1'b1);
    tick();
    chk("b2b_gap_stall", f_stall, 0);
    chk("b2b_gap_ack", d_ack, 0);
    xfer(1'b0, 2'd0, 64'h12, 64'h0, 64'h0000000000000003, 1'b0);
    tick(); chk("ack_pulse", d_ack, 0);

    xfer(1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h000000000000A55A, 1'b0);
    tick(); chk("ack_pulse", d_ack, 0);

    d_req = 1'b1; d_we = 1'b1; d_size = 2'd3; d_addr = 64'h40; d_wdata = 64'h1122334455667788;
    tick();
    tick();
    tick();
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("abort_pre_we", m_we, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_we", m_we, 0);
    chk("abort_stall", f_stall, 0);
    chk("abort_busy", d_busy, 0);
    chk("abort_ack", d_ack, 0);
    chk("abort_rdata", d_rdata, 0);
    tick();
    chk("abort_ack2", d_ack, 0);
    chk("abort_we2", m_we, 0);
    chk("abort_mem40", mem[8'h40], 8'h88);
    chk("abort_mem41", mem[8'h41], 8'h77);
    chk("abort_mem42", mem[8'h42], 8'h66);
    for (int k = 3; k < 8; k++) begin
      chk("abort_mem_keep", mem[8'h40 + 8'(k)], (8'h40 + 8'(k)) ^ 8'hA5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
